// File: rtl/chan_mux_pkg.sv
// rtl/chan_mux_pkg.sv - shared types and constants for the chan_mux_rr selector
//
// Purpose: mode encoding and statistics counter width used by chan_mux_rr.
// Ports:   none (package).
package chan_mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  localparam int STAT_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational rotate-priority arbiter
//
// Purpose: grants the first requesting channel after last_grant, wrapping,
//          with last_grant itself checked last. No grant when en is low.
// Ports:
//   req        in   N_CH   per-channel request
//   last_grant in   SEL_W  most recently granted channel
//   en         in   1      allow a grant this cycle
//   gnt        out  N_CH   one-hot grant (or zero)
//   gnt_idx    out  SEL_W  index of the granted channel
//   gnt_any    out  1      a grant was issued
module rr_arbiter #(
  parameter  int N_CH  = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] last_grant,
  input  logic             en,
  output logic [N_CH-1:0]  gnt,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic             hi_found;
  logic [SEL_W-1:0] hi_idx;
  logic             lo_found;
  logic [SEL_W-1:0] lo_idx;

  // Two ascending scans: channels above last_grant take priority, then the
  // wrapped range 0..last_grant. Together this is the rotated search order.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (req[i] && (i > int'(last_grant)) && !hi_found) begin
        hi_found = 1'b1;
        hi_idx   = SEL_W'(i);
      end
      if (req[i] && (i <= int'(last_grant)) && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = SEL_W'(i);
      end
    end
  end

  always_comb begin
    gnt_any = en & (hi_found | lo_found);
    gnt_idx = hi_found ? hi_idx : lo_idx;
    gnt     = '0;
    for (int i = 0; i < N_CH; i++) begin
      gnt[i] = gnt_any && (gnt_idx == SEL_W'(i));
    end
  end

endmodule

// File: rtl/chan_mux_rr.sv
// rtl/chan_mux_rr.sv - N-channel selector, fixed or round-robin, registered output
//
// Purpose: moves one word per cycle from a granted input channel into a
//          registered output with valid/ready on every side.
// Optional: define CHAN_MUX_STATS_EN to add per-channel saturating grant counters.
// Ports:
//   clk        in   1            rising-edge clock
//   rst        in   1            synchronous active-high reset
//   in_data    in   N_CH*WIDTH   channel i at [i*WIDTH +: WIDTH]
//   in_valid   in   N_CH         per-channel valid
//   in_ready   out  N_CH         per-channel ready, one-hot or zero
//   mode       in   1            0 = fixed, 1 = round-robin
//   sel_fixed  in   SEL_W        channel used in fixed mode
//   out_data   out  WIDTH        registered selected word
//   out_valid  out  1            output holds a word
//   out_ready  in   1            consumer accepts the word
//   grant_cnt  out  N_CH*16      per-channel transfer counts (CHAN_MUX_STATS_EN only)
//   out_ch     out  SEL_W        channel that produced out_data
module chan_mux_rr
  import chan_mux_pkg::*;
#(
  parameter  int WIDTH = 3,
  parameter  int N_CH  = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH*WIDTH-1:0]  in_data,
  input  logic [N_CH-1:0]        in_valid,
  output logic [N_CH-1:0]        in_ready,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel_fixed,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
`ifdef CHAN_MUX_STATS_EN
  output logic [N_CH*STAT_W-1:0] grant_cnt,
`endif
  output logic [SEL_W-1:0]       out_ch
);

  logic [WIDTH-1:0] out_data_q,   out_data_d;
  logic             out_valid_q,  out_valid_d;
  logic [SEL_W-1:0] out_ch_q,     out_ch_d;
  logic [SEL_W-1:0] last_grant_q, last_grant_d;

  mode_e            mode_s;
  logic             load_en;
  logic [N_CH-1:0]  sel_mask;
  logic [N_CH-1:0]  arb_req;
  logic [N_CH-1:0]  gnt;
  logic [SEL_W-1:0] gnt_idx;
  logic             gnt_any;
  logic [WIDTH-1:0] gnt_data;

  assign mode_s  = mode_e'(mode);
  assign load_en = !out_valid_q | out_ready;

  // Out-of-range sel_fixed matches no channel, so fixed mode simply stalls.
  always_comb begin
    sel_mask = '0;
    for (int i = 0; i < N_CH; i++) begin
      sel_mask[i] = (sel_fixed == SEL_W'(i));
    end
  end

  // In fixed mode at most one request survives, so the arbiter only decodes it.
  assign arb_req = (mode_s == MODE_RR) ? in_valid : (in_valid & sel_mask);

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req        (arb_req),
    .last_grant (last_grant_q),
    .en         (load_en & !rst),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx),
    .gnt_any    (gnt_any)
  );

  // A grant is only issued on a valid channel, so grant implies transfer.
  assign in_ready = gnt;

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt[i]) gnt_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_ch_d     = out_ch_q;
    last_grant_d = last_grant_q;
    if (gnt_any) begin
      out_data_d   = gnt_data;
      out_valid_d  = 1'b1;
      out_ch_d     = gnt_idx;
      last_grant_d = gnt_idx;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_ch_q     <= '0;
      last_grant_q <= SEL_W'(N_CH - 1);
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_ch_q     <= out_ch_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;

`ifdef CHAN_MUX_STATS_EN
  logic [STAT_W-1:0] cnt_q [N_CH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (rst) begin
        cnt_q[i] <= '0;
      end else if (gnt[i] && (cnt_q[i] != {STAT_W{1'b1}})) begin
        cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < N_CH; i++) begin
      grant_cnt[i*STAT_W +: STAT_W] = cnt_q[i];
    end
  end
`endif

endmodule
